// File: rtl/matrix_load_ctrl.sv
// Matrix line fetcher: pulls BUFFER_SIZE/8+1 beats per line over a single-outstanding
// read port and streams them, with full write sideband, into the input matrix buffer.
module matrix_load_ctrl #(
  parameter  int BUFFER_SIZE = 32,
  parameter  int ADDR_WIDTH  = 32,
  localparam int LW          = $clog2(BUFFER_SIZE) + 1,
  localparam int OW          = (BUFFER_SIZE > 8) ? $clog2(BUFFER_SIZE / 8) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LW-1:0]         num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [255:0]          mem_rdata,
  output logic [255:0]          data_in,
  output logic [LW-1:0]         index_in,
  output logic [OW-1:0]         index_offset,
  output logic [4:0]            addr_offset,
  output logic                  in_valid,
  input  logic                  in_ready,
  output logic                  in_last
);

  localparam int BEATS = BUFFER_SIZE / 8 + 1;
  localparam int BW    = $clog2(BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] line_addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LW-1:0]         lines_q;
  logic [LW-1:0]         line_cnt;
  logic [BW-1:0]         beat_cnt;
  logic                  beat_last;
  logic                  line_final;
  logic                  accept;
  logic                  handshake;

  // Beat address: line start rounded down to 32 bytes, plus the beat index.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] la,
                                                      input logic [BW-1:0] b);
    logic [ADDR_WIDTH-6:0] hi;
    hi = la[ADDR_WIDTH-1:5] + (ADDR_WIDTH-5)'(b);
    return {hi, 5'b0};
  endfunction

  assign accept     = (state == S_IDLE) && start;
  assign handshake  = (state == S_PUSH) && in_ready;
  assign beat_last  = (beat_cnt == BW'(BEATS - 1));
  assign line_final = (line_cnt == lines_q - LW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (num_lines == '0) ? S_DONE : S_REQ;
      S_REQ:  if (mem_gnt) state_nxt = S_WAIT;
      S_WAIT: if (mem_rvalid) state_nxt = S_PUSH;
      S_PUSH: if (in_ready) state_nxt = (line_final && beat_last) ? S_DONE : S_REQ;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch and line/beat walk; counters advance only on a buffer handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr <= '0;
      stride_q  <= '0;
      lines_q   <= '0;
      line_cnt  <= '0;
      beat_cnt  <= '0;
      data_in   <= '0;
    end else begin
      if (accept) begin
        line_addr <= base_addr;
        stride_q  <= stride;
        lines_q   <= num_lines;
        line_cnt  <= '0;
        beat_cnt  <= '0;
      end
      if ((state == S_WAIT) && mem_rvalid) data_in <= mem_rdata;
      if (handshake) begin
        if (beat_last) begin
          beat_cnt  <= '0;
          line_cnt  <= line_cnt + LW'(1);
          line_addr <= line_addr + stride_q;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  // Sideband is derived from the walk registers, so it holds while PUSH stalls.
  assign mem_addr     = beat_addr(line_addr, beat_cnt);
  assign index_in     = (beat_cnt == '0) ? '0 : line_cnt + LW'(1);
  assign index_offset = (beat_cnt == '0) ? '0 : OW'(beat_cnt - BW'(1));
  assign addr_offset  = line_addr[4:0];

  assign mem_req  = (state == S_REQ);
  assign in_valid = (state == S_PUSH);
  assign in_last  = (state == S_PUSH) && line_final && beat_last;
  assign done     = (state == S_DONE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Randomized bench for matrix_load_ctrl: a line/beat reference model built from
// base + L*stride arithmetic is checked against the captured request and write streams.
module tb_matrix_load_ctrl;
  localparam int BS = 32;
  localparam int LW = $clog2(BS) + 1;
  localparam int OW = $clog2(BS / 8);
  localparam int NB = BS / 8 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, busy, done, mem_req, mem_gnt, mem_rvalid;
  logic [31:0]   base_addr, stride, mem_addr;
  logic [LW-1:0] num_lines, index_in;
  logic [255:0]  mem_rdata, data_in;
  logic [OW-1:0] index_offset;
  logic [4:0]    addr_offset;
  logic          in_valid, in_ready, in_last;

  matrix_load_ctrl #(.BUFFER_SIZE(BS), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .num_lines(num_lines), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .data_in(data_in), .index_in(index_in),
    .index_offset(index_offset), .addr_offset(addr_offset), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last)
  );

  typedef struct {
    logic [255:0]  data;
    logic [LW-1:0] idx;
    logic [OW-1:0] off;
    logic [4:0]    aoff;
    logic          last;
  } beat_t;

  beat_t       hs_q[$];
  logic [31:0] req_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int max_gnt = 0, max_rv = 0, max_stall = 0;
  bit spurious = 0;
  int hold_at = -1;
  bit outstanding = 0;
  int gnt_wait = -1, rv_wait = 0, stall_wait = -1;
  logic [31:0] out_addr;
  int first_req_cyc, done_cyc, last_hs_cyc, done_cnt;

  bit            prev_stall = 0, prev_reqhold = 0;
  logic [255:0]  p_data;
  logic [LW-1:0] p_idx;
  logic [OW-1:0] p_off;
  logic [4:0]    p_aoff;
  logic          p_last;
  logic [31:0]   p_addr;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ (a >> 3) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] beat_data(input logic [31:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = mem_word(a + 32'(4 * i));
    return d;
  endfunction

  // One clock: observe outputs at the falling edge, then drive the memory and buffer side.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", in_valid, 1);
        chk("stall_data", data_in, p_data);
        chk("stall_index_in", index_in, p_idx);
        chk("stall_index_offset", index_offset, p_off);
        chk("stall_addr_offset", addr_offset, p_aoff);
        chk("stall_last", in_last, p_last);
      end
      if (prev_reqhold) begin
        chk("req_hold", mem_req, 1);
        chk("req_addr_hold", mem_addr, p_addr);
      end
      if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = {8{$urandom}};
    if (outstanding && !(hold_at >= 0 && req_q.size() == hold_at)) begin
      if (rv_wait == 0) begin
        mem_rvalid  = 1'b1;
        mem_rdata   = beat_data(out_addr);
        outstanding = 0;
      end else rv_wait--;
    end else if (spurious && !outstanding && $urandom_range(0, 3) == 0) begin
      mem_rvalid = 1'b1;
    end
    if (mem_req && !outstanding && !rst) begin
      if (gnt_wait < 0) gnt_wait = $urandom_range(0, max_gnt);
      if (gnt_wait == 0) begin
        mem_gnt     = 1'b1;
        out_addr    = mem_addr;
        req_q.push_back(mem_addr);
        outstanding = 1;
        rv_wait     = $urandom_range(0, max_rv);
        gnt_wait    = -1;
      end else gnt_wait--;
    end

    if (in_valid && !rst) begin
      if (stall_wait < 0) stall_wait = $urandom_range(0, max_stall);
      if (stall_wait == 0) begin
        in_ready   = 1'b1;
        stall_wait = -1;
        hs_q.push_back('{data_in, index_in, index_offset, addr_offset, in_last});
        last_hs_cyc = cyc;
      end else begin
        in_ready = 1'b0;
        stall_wait--;
      end
    end else in_ready = 1'($urandom_range(0, 1));

    if (busy) begin
      start     = 1'($urandom_range(0, 1));
      base_addr = $urandom;
      stride    = $urandom;
      num_lines = LW'($urandom_range(0, BS));
    end else start = 1'b0;

    prev_stall   = !rst && in_valid && !in_ready;
    prev_reqhold = !rst && mem_req && !mem_gnt;
    p_data = data_in; p_idx = index_in; p_off = index_offset;
    p_aoff = addr_offset; p_last = in_last; p_addr = mem_addr;
  endtask

  task automatic run_cmd(input logic [31:0] b, input logic [31:0] s, input int n);
    int budget, k, cmd_cyc;
    logic [31:0] la, ea;
    logic [511:0] pair;
    logic [255:0] ex;
    hs_q.delete();
    req_q.delete();
    first_req_cyc = -1; done_cyc = -1; done_cnt = 0; last_hs_cyc = -1;
    gnt_wait = -1; stall_wait = -1;
    tick();
    chk("idle_before_start", busy, 0);
    start = 1'b1; base_addr = b; stride = s; num_lines = LW'(n);
    cmd_cyc = cyc;
    budget = 0;
    while (done_cyc < 0 && budget < 20000) begin
      tick();
      budget++;
    end
    if (done_cyc < 0) begin
      chk("timeout_waiting_done", 0, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      outstanding = 0;
      return;
    end
    tick();
    chk("busy_after_done", busy, 0);
    chk("done_single_pulse", done_cnt, 1);
    chk("beat_count", hs_q.size(), n * NB);
    chk("req_count", req_q.size(), n * NB);
    if (n == 0) chk("done_latency_empty", done_cyc, cmd_cyc + 1);
    else begin
      chk("first_req_latency", first_req_cyc, cmd_cyc + 1);
      chk("done_after_last_hs", done_cyc, last_hs_cyc + 1);
    end
    k = 0;
    for (int L = 0; L < n; L++) begin
      la = b + 32'(L) * s;
      for (int bb = 0; bb < NB; bb++) begin
        ea = {la[31:5], 5'b0} + 32'(32 * bb);
        if (k < req_q.size()) chk("mem_addr", req_q[k], ea);
        if (k < hs_q.size()) begin
          chk("index_in", hs_q[k].idx, (bb == 0) ? 0 : L + 1);
          chk("index_offset", hs_q[k].off, (bb == 0) ? 0 : bb - 1);
          chk("addr_offset", hs_q[k].aoff, la[4:0]);
          chk("in_last", hs_q[k].last, (L == n - 1) && (bb == NB - 1));
          chk("data_in", hs_q[k].data, beat_data(ea));
        end
        k++;
      end
    end
    if (hs_q.size() == n * NB) begin
      for (int L = 0; L < n; L++) begin
        la = b + 32'(L) * s;
        for (int c = 0; c < NB - 1; c++) begin
          pair = {hs_q[L*NB + c + 1].data, hs_q[L*NB + c].data} >> (8 * la[4:0]);
          for (int j = 0; j < 8; j++) ex[32*j +: 32] = mem_word(la + 32'(32 * c + 4 * j));
          chk("chunk", pair[255:0], ex);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_in_valid"}, in_valid, 0);
    chk({tag, "_in_last"}, in_last, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_data_in"}, data_in, 0);
    chk({tag, "_index_in"}, index_in, 0);
    chk({tag, "_index_offset"}, index_offset, 0);
    chk({tag, "_addr_offset"}, addr_offset, 0);
  endtask

  initial begin
    int budget;
    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; num_lines = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; in_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    run_cmd(32'h1000, 32'd128, 1);
    run_cmd(32'h2014, 32'h100, 2);
    run_cmd(32'h3000, 32'h40, 0);
    run_cmd(32'h8004, 32'h84, BS);

    max_gnt = 4; max_rv = 4; max_stall = 10; spurious = 1;
    run_cmd(32'h2014, 32'h100, 2);
    run_cmd(32'hFFFF_FFE4, 32'h40, 3);
    for (int r = 0; r < 8; r++)
      run_cmd($urandom & 32'hFFFF_FFFC, $urandom_range(0, 2048) * 4, $urandom_range(1, 4));
    run_cmd(32'h4000, 32'h20, 0);

    // Reset while waiting for line 1 beat 0, then let the stale response arrive.
    max_gnt = 2; max_rv = 0; max_stall = 3; spurious = 0;
    hold_at = NB + 1;
    req_q.delete(); hs_q.delete(); gnt_wait = -1; stall_wait = -1;
    tick();
    start = 1'b1; base_addr = 32'h5008; stride = 32'h200; num_lines = LW'(3);
    budget = 0;
    while (!(req_q.size() == NB + 1 && outstanding) && budget < 5000) begin
      tick();
      budget++;
    end
    chk("reach_line1_wait", req_q.size(), NB + 1);
    tick();
    chk("in_wait_no_req", mem_req, 0);
    chk("in_wait_no_valid", in_valid, 0);
    rst = 1'b1;
    tick();
    check_reset_outputs("midburst_reset");
    rst = 1'b0;
    hold_at = -1;
    rv_wait = 0;
    tick();
    chk("late_resp_delivered", outstanding, 0);
    tick();
    chk("late_resp_no_valid", in_valid, 0);
    chk("late_resp_idle", busy, 0);
    chk("late_resp_data", data_in, 0);
    outstanding = 0;
    run_cmd(32'h6010, 32'h30, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
